// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ALU, data-SRAM request, forwarding to decode).
// Define EX_DIV_EN to build the iterative 32-step DIV/DIVU unit and HI/LO outputs.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 141
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_rf_bus,
    output logic                    ex_is_load,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    logic [ID_TO_EX_WD-1:0] bus_q;

    // Decode-to-execute register: bubble when only this stage stops, hold when both stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q <= {ID_TO_EX_WD{1'b0}};
        end else if (stall[2] && !stall[3]) begin
            bus_q <= {ID_TO_EX_WD{1'b0}};
        end else if (!stall[2]) begin
            bus_q <= id_to_ex_bus;
        end else begin
            bus_q <= bus_q;
        end
    end

    logic [31:0] pc_s, inst_s, rdata1_s, rdata2_s;
    logic [11:0] alu_op_s;
    logic [2:0]  sel_src1_s;
    logic [3:0]  sel_src2_s;
    logic        ram_en_s, rf_we_s, sel_rf_res_s;
    logic [3:0]  ram_wen_s;
    logic [4:0]  rf_waddr_s;

    assign pc_s         = bus_q[158:127];
    assign inst_s       = bus_q[126:95];
    assign alu_op_s     = bus_q[94:83];
    assign sel_src1_s   = bus_q[82:80];
    assign sel_src2_s   = bus_q[79:76];
    assign ram_en_s     = bus_q[75];
    assign ram_wen_s    = bus_q[74:71];
    assign rf_we_s      = bus_q[70];
    assign rf_waddr_s   = bus_q[69:65];
    assign sel_rf_res_s = bus_q[64];
    assign rdata1_s     = bus_q[63:32];
    assign rdata2_s     = bus_q[31:0];

    logic [31:0] src1_s, src2_s, ex_result_s;

    assign src1_s = ({32{sel_src1_s[0]}} & rdata1_s)
                  | ({32{sel_src1_s[1]}} & pc_s)
                  | ({32{sel_src1_s[2]}} & {27'd0, inst_s[10:6]});

    assign src2_s = ({32{sel_src2_s[0]}} & rdata2_s)
                  | ({32{sel_src2_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
                  | ({32{sel_src2_s[2]}} & 32'd8)
                  | ({32{sel_src2_s[3]}} & {16'd0, inst_s[15:0]});

    // AND-OR mux over the one-hot op vector so an empty op yields zero.
    assign ex_result_s =
          ({32{alu_op_s[11]}} & (src1_s + src2_s))
        | ({32{alu_op_s[10]}} & (src1_s - src2_s))
        | ({32{alu_op_s[9]}}  & {31'd0, ($signed(src1_s) < $signed(src2_s))})
        | ({32{alu_op_s[8]}}  & {31'd0, (src1_s < src2_s)})
        | ({32{alu_op_s[7]}}  & (src1_s & src2_s))
        | ({32{alu_op_s[6]}}  & ~(src1_s | src2_s))
        | ({32{alu_op_s[5]}}  & (src1_s | src2_s))
        | ({32{alu_op_s[4]}}  & (src1_s ^ src2_s))
        | ({32{alu_op_s[3]}}  & (src2_s << src1_s[4:0]))
        | ({32{alu_op_s[2]}}  & (src2_s >> src1_s[4:0]))
        | ({32{alu_op_s[1]}}  & 32'($signed(src2_s) >>> src1_s[4:0]))
        | ({32{alu_op_s[0]}}  & {src2_s[15:0], 16'd0});

    logic        hilo_we_s;
    logic [31:0] hi_s, lo_s;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;
    logic        is_div_s, div_signed_s;
    logic [33:0] trial_s;

    assign is_div_s = (inst_s[31:26] == 6'd0) && (inst_s[15:6] == 10'd0)
                   && ((inst_s[5:0] == 6'b011010) || (inst_s[5:0] == 6'b011011));
    assign div_signed_s = ~inst_s[0];
    // Trial subtraction of one restoring step; borrow in bit 33 means "too small".
    assign trial_s = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};

    // Divider state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            dvd_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
        end
    end

    // Divider next-state: latch magnitudes, 32 restoring steps, then present HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvz_d   = dvz_q;
        case (state_q)
            S_IDLE: begin
                if (is_div_s) begin
                    state_d = S_BUSY;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    quo_d   = (div_signed_s && rdata1_s[31]) ? neg32(rdata1_s) : rdata1_s;
                    dvs_d   = (div_signed_s && rdata2_s[31]) ? neg32(rdata2_s) : rdata2_s;
                    dvd_d   = rdata1_s;
                    qneg_d  = div_signed_s && (rdata1_s[31] ^ rdata2_s[31]);
                    rneg_d  = div_signed_s && rdata1_s[31];
                    dvz_d   = (rdata2_s == 32'd0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 5'd1;
                if (trial_s[33]) begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end else begin
                    rem_d = trial_s[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (stall[2]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stallreq_for_ex = (state_q == S_BUSY) || ((state_q == S_IDLE) && is_div_s);
    assign hilo_we_s = (state_q == S_DONE);
    assign lo_s = !hilo_we_s ? 32'd0 :
                  dvz_q      ? 32'hFFFF_FFFF :
                  qneg_q     ? neg32(quo_q) : quo_q;
    assign hi_s = !hilo_we_s ? 32'd0 :
                  dvz_q      ? dvd_q :
                  rneg_q     ? neg32(rem_q) : rem_q;

    logic unused_s;
    assign unused_s = ^{stall[5:4], stall[1:0], inst_s[25:16]};
`else
    assign stallreq_for_ex = 1'b0;
    assign hilo_we_s       = 1'b0;
    assign hi_s            = 32'd0;
    assign lo_s            = 32'd0;

    logic unused_s;
    assign unused_s = ^{stall[5:4], stall[1:0], inst_s[31:16]};
`endif

    assign ex_to_mem_bus = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s,
                            ex_result_s, hilo_we_s, hi_s, lo_s};
    assign ex_to_rf_bus    = {rf_we_s, rf_waddr_s, ex_result_s};
    assign ex_is_load      = sel_rf_res_s & ram_en_s;
    assign data_sram_en    = ram_en_s;
    assign data_sram_wen   = ram_wen_s;
    assign data_sram_addr  = ex_result_s;
    assign data_sram_wdata = rdata2_s;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven ALU/SRAM/forwarding vectors plus directed stall,
// reset and divider sequences for ex_stage.
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall_man;
    logic [5:0]   stall;
    logic [158:0] bus;
    logic [140:0] ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         ex_is_load;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq;

    int n_checks = 0;
    int n_fail   = 0;

    // Stall controller model: a divide request stops stages 0..3.
    assign stall = stall_man | {2'b00, {4{stallreq}}};

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .ex_is_load      (ex_is_load),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [158:0] bus;
        logic [31:0]  res;
        logic         load;
    } vec_t;

    vec_t vt[19];

    function automatic logic [158:0] mk(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
        input logic we, input logic [4:0] wa, input logic selr,
        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, selr, r1, r2};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] all_out();
        return {20'd0, ex_to_mem_bus[140:0] ^ 141'd0, 1'b0} ^ {121'd0, ex_to_rf_bus, ex_is_load}
             ^ {87'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq};
    endfunction

`ifdef EX_DIV_EN
    task automatic run_div(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi, input int hold);
        int n;
        @(negedge clk);
        bus = mk(32'h0, {26'd0, func}, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                 1'b0, 5'd0, 1'b0, a, b);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stallreq) break;
            n++;
        end
        chk("div_stall_cycles", 160'(n), 160'd33);
        chk("div_hilo", 160'(ex_to_mem_bus[64:0]), 160'({1'b1, ehi, elo}));
        for (int h = 0; h < hold; h++) begin
            stall_man = 6'b001100;
            @(negedge clk);
            chk("div_done_held", 160'({stallreq, ex_to_mem_bus[64:0]}), 160'({1'b0, 1'b1, ehi, elo}));
        end
        stall_man = 6'd0;
        bus = 159'd0;
        @(posedge clk);
        #1;
        chk("div_after_done", 160'({stallreq, ex_to_mem_bus[64:0]}), 160'd0);
    endtask
`endif

    initial begin
        vt[0]  = '{mk(32'hBFC0_0000, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'd2), 32'h0000_0001, 1'b0};
        vt[1]  = '{mk(32'hBFC0_0004, 32'hAC00_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF), 32'h0000_0FFC, 1'b0};
        vt[2]  = '{mk(32'hBFC0_0008, 32'h8C00_0010, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd8, 1'b1, 32'h0000_2000, 32'h0), 32'h0000_2010, 1'b1};
        vt[3]  = '{mk(32'h0, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd5, 32'd7), 32'hFFFF_FFFE, 1'b0};
        vt[4]  = '{mk(32'h0, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd10, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd1, 1'b0};
        vt[5]  = '{mk(32'h0, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0, 1'b0};
        vt[6]  = '{mk(32'h0, 32'h0, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd12, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00), 32'hF000_F000, 1'b0};
        vt[7]  = '{mk(32'h0, 32'h0, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd13, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000), 32'h0000_0F0F, 1'b0};
        vt[8]  = '{mk(32'h0, 32'h3400_8001, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd14, 1'b0, 32'h1234_0000, 32'hFFFF_FFFF), 32'h1234_8001, 1'b0};
        vt[9]  = '{mk(32'h0, 32'h0, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd15, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000), 32'h5555_5555, 1'b0};
        vt[10] = '{mk(32'h0, 32'h0000_0100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd16, 1'b0, 32'hFFFF_FFFF, 32'h0000_000F), 32'h0000_00F0, 1'b0};
        vt[11] = '{mk(32'h0, 32'h0000_0102, 12'h004, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd17, 1'b0, 32'h0, 32'h8000_0000), 32'h0800_0000, 1'b0};
        vt[12] = '{mk(32'h0, 32'h0000_0103, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd18, 1'b0, 32'h0, 32'h8000_0000), 32'hF800_0000, 1'b0};
        vt[13] = '{mk(32'h0, 32'h3C00_1234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd19, 1'b0, 32'h0, 32'h0), 32'h1234_0000, 1'b0};
        vt[14] = '{mk(32'hBFC0_0100, 32'h0, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0), 32'hBFC0_0108, 1'b0};
        vt[15] = '{mk(32'h0, 32'h0, 12'h000, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd20, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0), 32'h0, 1'b0};
        vt[16] = '{mk(32'h0, 32'h0, 12'h008, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd21, 1'b0, 32'h0000_0024, 32'h1), 32'h0000_0010, 1'b0};
        vt[17] = '{mk(32'h0, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd22, 1'b0, 32'd1, 32'hFFFF_FFFF), 32'd1, 1'b0};
        vt[18] = '{mk(32'h0, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd23, 1'b0, 32'd1, 32'hFFFF_FFFF), 32'd0, 1'b0};

        rst = 1'b0;
        stall_man = 6'd0;
        bus = vt[0].bus;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 160'd0);
        chk("reset_mem_bus", 160'(ex_to_mem_bus), 160'd0);
        bus = 159'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("bubble_after_reset", 160'({ex_to_mem_bus, ex_to_rf_bus}), 160'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            bus = vt[i].bus;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rf_bus", i), 160'(ex_to_rf_bus),
                160'({vt[i].bus[70], vt[i].bus[69:65], vt[i].res}));
            chk($sformatf("vec%0d_sram", i), 160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
                160'({vt[i].bus[75], vt[i].bus[74:71], vt[i].res, vt[i].bus[31:0]}));
            chk($sformatf("vec%0d_load_stallreq", i), 160'({ex_is_load, stallreq}), 160'({vt[i].load, 1'b0}));
            chk($sformatf("vec%0d_mem_bus", i), 160'(ex_to_mem_bus),
                160'({vt[i].bus[158:127], vt[i].bus[75], vt[i].bus[74:71], vt[i].bus[64],
                      vt[i].bus[70], vt[i].bus[69:65], vt[i].res, 65'd0}));
        end

        // Bubble: only this stage stopped while a valid instruction is offered.
        @(negedge clk);
        bus = vt[0].bus;
        @(posedge clk);
        #1;
        chk("pre_bubble_rf_bus", 160'(ex_to_rf_bus), 160'({1'b1, 5'd5, 32'd1}));
        @(negedge clk);
        stall_man = 6'b000100;
        bus = vt[1].bus;
        @(posedge clk);
        #1;
        chk("bubble_rf_bus", 160'(ex_to_rf_bus), 160'd0);
        chk("bubble_mem_bus", 160'({ex_to_mem_bus, data_sram_en}), 160'd0);

        // Hold: this stage and the next both stopped.
        @(negedge clk);
        stall_man = 6'd0;
        bus = vt[0].bus;
        @(negedge clk);
        stall_man = 6'b001100;
        bus = vt[1].bus;
        @(posedge clk);
        #1;
        chk("hold_rf_bus", 160'(ex_to_rf_bus), 160'({1'b1, 5'd5, 32'd1}));
        stall_man = 6'd0;

        // Asynchronous reset mid-run clears outputs without a clock edge.
        @(negedge clk);
        bus = vt[1].bus;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 160'd0);
        @(negedge clk);
        bus = 159'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_bubble", all_out(), 160'd0);

`ifdef EX_DIV_EN
        run_div(6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div(6'b011011, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 3);
        run_div(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_div(6'b011011, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0);
        run_div(6'b011010, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);

        // Reset in the middle of a divide discards it and releases the stall.
        @(negedge clk);
        bus = mk(32'h0, 32'h0000_001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                 1'b0, 5'd0, 1'b0, 32'd50, 32'd3);
        repeat (6) @(negedge clk);
        chk("div_busy_stallreq", 160'(stallreq), 160'd1);
        rst = 1'b0;
        bus = 159'd0;
        #1;
        chk("div_reset_release", 160'({stallreq, ex_to_mem_bus[64:0]}), 160'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("div_reset_no_restart", 160'({stallreq, ex_to_mem_bus[64:0]}), 160'd0);
`else
        @(negedge clk);
        bus = mk(32'h0, 32'h0000_001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                 1'b0, 5'd0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk);
        #1;
        chk("div_disabled_nop", 160'({stallreq, ex_to_mem_bus[64:0]}), 160'd0);
        @(negedge clk);
        bus = 159'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
